// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared constants and types for the ARM-style fetch pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package arm_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    // Fetch FSM: normal fetching, or waiting to drop one stale response
    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO holding {pc+4, instruction} prefetch words.
//                Flush has priority over push and pop.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int               c_pw    = $clog2(DEPTH);
    localparam int               c_cw    = c_pw + 1;
    localparam logic [c_cw-1:0]  c_depth = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !i_flush && !w_full;
    assign w_do_pop  = i_pop  && !i_flush && !w_empty;

    // Storage write at the tail; contents need no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cw'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_cw'(1);
            end
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage with prefetch queue and IF/ID output
//                register. Handles freeze stalls and execute-stage redirects.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
    import arm_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        pc_out,
    output logic               instr_valid
);

    localparam int              c_cw    = $clog2(DEPTH) + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0]        r_fetch_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [31:0]        r_pc;
    logic               r_valid;

    logic [c_cw-1:0]    w_count;
    logic               w_full;
    logic               w_empty;
    logic [63:0]        w_pop_data;

    logic [31:0]        w_pc_plus4;
    logic               w_ack_ok;
    logic               w_load;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;

    // Request depends only on registered state, so freeze never reaches it combinationally
    assign imem_req   = (r_state == FETCH) && (w_count < c_depth);
    assign imem_addr  = r_fetch_pc;
    assign w_pc_plus4 = r_fetch_pc + 32'd4;

    // A response is only accepted for our own live request; a redirect kills it
    assign w_ack_ok = imem_ack && imem_req && !branch_taken;
    assign w_load   = !freeze && !branch_taken;
    assign w_bypass = w_ack_ok && w_empty && w_load;
    assign w_push   = w_ack_ok && !w_bypass && !w_full;
    assign w_pop    = w_load && !w_empty;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({w_pc_plus4, imem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (branch_taken),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Next-state: a redirect with an unanswered request must swallow one ack
    always_comb begin
        w_state_nxt = r_state;
        if (branch_taken) begin
            if (r_state == DISCARD) begin
                w_state_nxt = imem_ack ? FETCH : DISCARD;
            end else if (imem_req && !imem_ack) begin
                w_state_nxt = DISCARD;
            end else begin
                w_state_nxt = FETCH;
            end
        end else if ((r_state == DISCARD) && imem_ack) begin
            w_state_nxt = FETCH;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC: redirect wins, otherwise advance on each accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_fetch_pc <= branch_addr;
        end else if (w_ack_ok) begin
            r_fetch_pc <= w_pc_plus4;
        end
    end

    // IF/ID register: queue head first, then bypassed ack, else a bubble
    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!freeze) begin
            if (!w_empty) begin
                r_pc    <= w_pop_data[63:32];
                r_instr <= w_pop_data[31:0];
                r_valid <= 1'b1;
            end else if (w_bypass) begin
                r_pc    <= w_pc_plus4;
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_pc    <= '0;
                r_valid <= 1'b0;
            end
        end
    end

    assign instr_out   = r_instr;
    assign pc_out      = r_pc;
    assign instr_valid = r_valid;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: directed vector table,
//                hand-written redirect/reset sequences, randomized traffic
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;
    import arm_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid)
    );

    // Memory: returns word = address; mem_waits wait states, sampled at request start.
    // A latched request is always answered, even if the requester lets go.
    int          mem_waits = 0;
    logic        mem_busy  = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_addr  = '0;

    assign imem_ack   = mem_busy ? (mem_cnt == 0) : (imem_req && (mem_waits == 0));
    assign imem_rdata = mem_busy ? mem_addr : imem_addr;

    always @(posedge clk) begin
        if (rst) begin
            mem_busy <= 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end else if (imem_req && (mem_waits != 0)) begin
            mem_busy <= 1'b1;
            mem_addr <= imem_addr;
            mem_cnt  <= mem_waits - 1;
        end
    end

    // Reference model: list of pending {pc+4, word} pairs plus the output register
    logic [63:0] mq[$];
    logic [31:0] m_pc     = '0;
    bit          m_disc   = 1'b0;
    logic [31:0] m_instr  = '0;
    logic [31:0] m_pcout  = '0;
    bit          m_valid  = 1'b0;
    bit          m_init   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          req;
        bit          ack;
        bit          acc;
        logic [31:0] rd;
        logic [63:0] word;
        req = !m_disc && (mq.size() < DEPTH);
        ack = imem_ack;
        rd  = imem_rdata;
        if (m_init && !rst) begin
            check("imem_req", {31'd0, imem_req}, {31'd0, req});
            if (req) check("imem_addr", imem_addr, m_pc);
        end
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC; m_disc = 1'b0;
            m_instr = NOP_INSTR; m_pcout = '0; m_valid = 1'b0;
            m_init = 1'b1;
        end else if (branch_taken) begin
            mq.delete();
            m_instr = NOP_INSTR; m_pcout = '0; m_valid = 1'b0;
            m_disc  = (m_disc || req) && !ack;
            m_pc    = branch_addr;
        end else begin
            acc  = req && ack;
            if (m_disc && ack) m_disc = 1'b0;
            word = {m_pc + 32'd4, rd};
            if (acc) m_pc = m_pc + 32'd4;
            if (!freeze) begin
                if (mq.size() > 0) begin
                    {m_pcout, m_instr} = mq.pop_front();
                    m_valid = 1'b1;
                    if (acc) mq.push_back(word);
                end else if (acc) begin
                    {m_pcout, m_instr} = word;
                    m_valid = 1'b1;
                end else begin
                    m_instr = NOP_INSTR; m_pcout = '0; m_valid = 1'b0;
                end
            end else if (acc) begin
                mq.push_back(word);
            end
        end
    endtask

    task automatic cmp_out();
        if (m_init) begin
            check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            check("instr_out", instr_out, m_instr);
            if (m_valid) check("pc_out", pc_out, m_pcout);
        end
    endtask

    // One clock: inputs already applied at the falling edge
    task automatic step();
        #1;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cmp_out();
    endtask

    typedef struct {
        bit          rst;
        bit          frz;
        bit          br;
        logic [31:0] ba;
        bit          ev;
        logic [31:0] ei;
        logic [31:0] ep;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        int k;
        int r;

        // Zero-wait memory; expected outputs seen after the edge of each row
        tbl[0]  = '{1, 0, 0, 32'h0,   0, NOP_INSTR, 32'h0};
        tbl[1]  = '{0, 0, 0, 32'h0,   1, 32'h0,     32'h4};
        tbl[2]  = '{0, 0, 0, 32'h0,   1, 32'h4,     32'h8};
        tbl[3]  = '{0, 0, 0, 32'h0,   1, 32'h8,     32'hC};
        tbl[4]  = '{0, 1, 0, 32'h0,   1, 32'h8,     32'hC};
        tbl[5]  = '{0, 1, 0, 32'h0,   1, 32'h8,     32'hC};
        tbl[6]  = '{0, 1, 0, 32'h0,   1, 32'h8,     32'hC};
        tbl[7]  = '{0, 1, 0, 32'h0,   1, 32'h8,     32'hC};
        tbl[8]  = '{0, 0, 0, 32'h0,   1, 32'hC,     32'h10};
        tbl[9]  = '{0, 0, 0, 32'h0,   1, 32'h10,    32'h14};
        tbl[10] = '{0, 0, 0, 32'h0,   1, 32'h14,    32'h18};
        tbl[11] = '{0, 0, 1, 32'h100, 0, NOP_INSTR, 32'h0};
        tbl[12] = '{0, 0, 0, 32'h0,   1, 32'h100,   32'h104};
        tbl[13] = '{0, 0, 0, 32'h0,   1, 32'h104,   32'h108};
        tbl[14] = '{0, 1, 0, 32'h0,   1, 32'h104,   32'h108};
        tbl[15] = '{0, 1, 0, 32'h0,   1, 32'h104,   32'h108};
        tbl[16] = '{0, 1, 1, 32'h200, 0, NOP_INSTR, 32'h0};
        tbl[17] = '{0, 0, 0, 32'h0,   1, 32'h200,   32'h204};
        tbl[18] = '{0, 0, 0, 32'h0,   1, 32'h204,   32'h208};

        mem_waits = 0;
        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; freeze = tbl[i].frz;
            branch_taken = tbl[i].br; branch_addr = tbl[i].ba;
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].ev});
            check($sformatf("vec%0d_instr", i), instr_out, tbl[i].ei);
            if (tbl[i].ev || tbl[i].rst) check($sformatf("vec%0d_pc", i), pc_out, tbl[i].ep);
        end
        rst = 0; freeze = 0; branch_taken = 0;

        // Two wait states: two bubbles then one valid instruction, repeating
        mem_waits = 2; rst = 1;
        step();
        rst = 0; nvalid = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (instr_valid) nvalid++;
        end
        check("two_wait_valid_count", nvalid, 3);

        // Redirect while the request to 0x20 is still waiting
        mem_waits = 0; rst = 1;
        step();
        rst = 0;
        repeat (8) step();
        check("pre_branch_addr", imem_addr, 32'h20);
        mem_waits = 2;
        step();
        branch_taken = 1; branch_addr = 32'h100;
        step();
        branch_taken = 0; mem_waits = 0;
        check("branch_bubble", {31'd0, instr_valid}, 32'd0);
        check("discard_no_req", {31'd0, imem_req}, 32'd0);
        step();
        check("redirect_req", {31'd0, imem_req}, 32'd1);
        check("redirect_addr", imem_addr, 32'h100);
        k = 0;
        while (!instr_valid && k < 8) begin
            step();
            k++;
        end
        if (!instr_valid) begin
            check("redirect_timeout", {31'd0, instr_valid}, 32'd1);
        end else begin
            check("redirect_first_pc", pc_out, 32'h104);
            check("redirect_first_instr", instr_out, 32'h100);
        end

        // Reset lands exactly on the cycle the memory acks
        mem_waits = 2;
        step();
        step();
        rst = 1;
        step();
        rst = 0; mem_waits = 0;
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr_out, NOP_INSTR);
        check("rst_pc", pc_out, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_req", {31'd0, imem_req}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(99) < 2);
            freeze       = ($urandom_range(99) < 30);
            branch_taken = ($urandom_range(99) < 12);
            r            = $urandom_range(9);
            branch_addr  = (r == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            mem_waits    = ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 3);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register feeding the decode stage.
- Owns the PC and issues requests over a req/ack instruction-memory port (zero or more wait states).
- Buffers returned words in a small prefetch queue; presents one registered {instruction, PC+4} pair per cycle.
- Honours the hazard stall (freeze) and branch redirects from the execute stage.

Parameters:
- DEPTH, 2, prefetch queue entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  hazard stall; holds the output register.
- branch_taken  input  1  redirect request from execute.
- branch_addr  input  32  redirect target, word aligned.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; stable while imem_req is high and unacked.
- imem_ack  input  1  one-cycle response strobe; may coincide with the first imem_req cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack is high.
- instr_out  output  32  Instruction to decode.
- pc_out  output  32  PC+4 of instr_out (decode PCin).
- instr_valid  output  1  instr_out holds a real instruction.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - fetch_pc = RESET_PC; queue empty; state = FETCH; no outstanding request.
  - instr_out = NOP_INSTR (32'hE1A00000); pc_out = 0; instr_valid = 0.
  - Reset mid-request abandons the request; any ack in the reset cycle is ignored.
- FSM, two states:
  - FETCH: imem_req = (count < DEPTH); imem_addr = fetch_pc. On imem_ack, fetch_pc += 4 and {fetch_pc+4, imem_rdata} is delivered.
  - DISCARD: entered when a branch arrives with a request outstanding (imem_req high, no ack that cycle). imem_req = 0. The next imem_ack is dropped; then return to FETCH at the new fetch_pc.
- Delivery:
  - If the queue is empty, freeze = 0 and the output register is being loaded this cycle, the ack bypasses straight into the output register.
  - Otherwise the ack pushes to the queue tail.
- Output register update (when freeze = 0 and branch_taken = 0):
  - Queue non-empty: pop head to {pc_out, instr_out}; instr_valid = 1.
  - Queue empty, no bypass: load NOP_INSTR, instr_valid = 0.
- freeze = 1 (branch_taken = 0):
  - Output register holds; no pop.
  - Fetching continues until count == DEPTH; acks still push.
- Branch (branch_taken = 1) has priority over freeze and over any ack in the same cycle:
  - Queue flushed; output register loads NOP_INSTR with instr_valid = 0; fetch_pc = branch_addr.
  - A same-cycle ack is dropped.
  - If a request is outstanding and unacked, go to DISCARD; otherwise start fetching branch_addr next cycle.
- Back-to-back branches: the latest target wins; DISCARD still drops exactly one ack.
- Full queue: imem_req = 0. A pop in the same cycle re-enables the request the following cycle; no combinational path from freeze to imem_req.
- Empty queue: bubbles are output with instr_valid = 0.
- Occupancy: count is 0..DEPTH. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 0. pc_out is always the fetch address + 4.
- Throughput and latency with zero-wait memory:
  - One instruction per cycle.
  - First valid instruction appears one cycle after reset deasserts.
  - First valid instruction appears one cycle after a branch redirect plus the memory latency.

Decomposition:
- Shared package arm_pkg:
  - NOP_INSTR = 32'hE1A00000.
  - INSTR_W = 32.
  - fetch FSM enum {FETCH, DISCARD}.
- Sub-module fetch_queue: synchronous FIFO parameterised by DEPTH and width 64, with push, pop, flush, full, empty and count. Flush has priority over push.
- FSM, PC and output register stay in fetch_stage.

Test Plan:
- Reset, zero-wait memory returning word = address:
  - Cycle 1: instr_out = 0, pc_out = 4, valid = 1.
  - Cycle 2: instr_out = 4, pc_out = 8.
  - One instruction per cycle thereafter.
- Two wait states per fetch (ack every 3rd cycle):
  - Outputs alternate two bubbles (NOP_INSTR, valid = 0) with one valid instruction.
  - imem_addr is stable while waiting.
- freeze held 4 cycles with zero-wait memory:
  - Output holds the same instr/pc.
  - Queue fills to DEPTH = 2, then imem_req drops.
  - On release, the queued words appear in order with no loss or duplication.
- branch_taken with branch_addr = 32'h100 while a request to 32'h20 is outstanding:
  - Output bubble next cycle; state DISCARD.
  - The ack carrying word 32'h20 is dropped; the next request address is 32'h100.
  - First valid pc_out = 32'h104.
- branch_taken and freeze in the same cycle with 2 words queued: queue flushed, output NOP valid = 0, fetch_pc = branch_addr.
- rst asserted mid-wait, with the memory acking in the reset cycle: ack ignored; next imem_addr = RESET_PC; outputs at reset values.
